// File: rtl/col_to_block_converter_if.sv
// AXI4-Stream bundle shared by the column input and the block-row output of
// col_to_block_converter. The master drives the payload and the slave drives tready.
interface axi4_stream_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic                  tuser;
  logic                  tid;
  logic                  tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/col_to_block_converter.sv
// col_to_block_converter: two-bank ping-pong transposer. Column beats (LINES
// vertically adjacent pixels) fill one bank while the other bank is read out
// row by row as LINESxLINES blocks for the 2D DCT. Short strips (early tlast)
// are edge-padded by replicating the last written column.
// Optional build macro LEVEL_SHIFT_EN: output pixels are level shifted by
// -2^(PX_WIDTH-1) (JPEG), combinationally on the read path.
module col_to_block_converter #(
  parameter int unsigned PX_WIDTH    = 8,
  parameter int unsigned LINES       = 8,
  parameter int unsigned FRAME_RES_X = 1280
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  par_video_i,
  axi4_stream_if.master block_o
);

  localparam int unsigned BUS_W = ((LINES * PX_WIDTH + 7) / 8) * 8;
  localparam int unsigned CW    = $clog2(LINES);

  if ((LINES < 2) || ((LINES & (LINES - 1)) != 0)) begin : g_bad_lines
    $error("LINES must be a power of two and at least 2");
  end
  if ((FRAME_RES_X % LINES) != 0) begin : g_bad_res
    $error("FRAME_RES_X must be a multiple of LINES");
  end

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_st_e;

  typedef logic [PX_WIDTH-1:0] px_t;

  bank_st_e        st_q       [2];
  bank_st_e        st_d       [2];
  logic [CW-1:0]   last_col_q [2];
  logic [CW-1:0]   last_col_d [2];
  logic            tlast_f_q  [2];
  logic            tlast_f_d  [2];
  logic            tuser_f_q  [2];
  logic            tuser_f_d  [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [CW-1:0]   row_cnt_q, row_cnt_d;

  // Pixel storage, indexed [bank][line][column]; contents only matter once a bank is FULL.
  px_t             pix_q [2][LINES][LINES];

  logic            wr_ready;
  logic            wr_acc;
  logic            wr_end;
  logic            rd_valid;
  logic            rd_hs;
  logic            rd_end;
  logic [BUS_W-1:0] row_data;
  logic            unused_in;

  // Handshake qualifiers; tready is held low while reset is asserted.
  assign wr_ready = rst_n_i && (st_q[wr_bank_q] != BANK_FULL);
  assign wr_acc   = par_video_i.tvalid && wr_ready;
  assign wr_end   = wr_acc && ((col_cnt_q == CW'(LINES - 1)) || par_video_i.tlast);
  assign rd_valid = (st_q[rd_bank_q] == BANK_FULL);
  assign rd_hs    = rd_valid && block_o.tready;
  assign rd_end   = rd_hs && (row_cnt_q == CW'(LINES - 1));

  assign unused_in = ^{par_video_i.tstrb, par_video_i.tkeep, par_video_i.tid, par_video_i.tdest};

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned b = 0; b < 2; b++) begin
        st_q[b]       <= BANK_EMPTY;
        last_col_q[b] <= '0;
        tlast_f_q[b]  <= 1'b0;
        tuser_f_q[b]  <= 1'b0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        st_q[b]       <= st_d[b];
        last_col_q[b] <= last_col_d[b];
        tlast_f_q[b]  <= tlast_f_d[b];
        tuser_f_q[b]  <= tuser_f_d[b];
      end
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Next-state: the write side and read side never touch the same bank in one
  // cycle, since writing needs a non-FULL bank and reading needs a FULL one.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      st_d[b]       = st_q[b];
      last_col_d[b] = last_col_q[b];
      tlast_f_d[b]  = tlast_f_q[b];
      tuser_f_d[b]  = tuser_f_q[b];
    end
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;

    if (wr_acc) begin
      st_d[wr_bank_q] = wr_end ? BANK_FULL : BANK_FILLING;
      col_cnt_d       = wr_end ? '0 : col_cnt_q + CW'(1);
      if (col_cnt_q == '0) begin
        tuser_f_d[wr_bank_q] = par_video_i.tuser;
      end
      if (wr_end) begin
        last_col_d[wr_bank_q] = col_cnt_q;
        tlast_f_d[wr_bank_q]  = par_video_i.tlast;
        wr_bank_d             = ~wr_bank_q;
      end
    end

    if (rd_hs) begin
      row_cnt_d = rd_end ? '0 : row_cnt_q + CW'(1);
      if (rd_end) begin
        st_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d       = ~rd_bank_q;
      end
    end
  end

  // Column write into the filling bank.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < LINES; k++) begin
        pix_q[wr_bank_q][k][col_cnt_q] <= par_video_i.tdata[k*PX_WIDTH +: PX_WIDTH];
      end
    end
  end

  // Row read mux with edge padding: columns past last_col replicate last_col.
  always_comb begin : rd_mux
    logic [CW-1:0] src;
    px_t           px;
    row_data = '0;
    src      = '0;
    px       = '0;
    for (int unsigned c = 0; c < LINES; c++) begin
      src = (CW'(c) > last_col_q[rd_bank_q]) ? last_col_q[rd_bank_q] : CW'(c);
      px  = pix_q[rd_bank_q][row_cnt_q][src];
`ifdef LEVEL_SHIFT_EN
      px  = px - (px_t'(1) << (PX_WIDTH - 1));
`endif
      row_data[c*PX_WIDTH +: PX_WIDTH] = px;
    end
  end

  assign par_video_i.tready = wr_ready;

  // Payload is forced to zero while idle so reset and idle outputs are clean.
  assign block_o.tvalid = rd_valid;
  assign block_o.tdata  = rd_valid ? row_data : '0;
  assign block_o.tlast  = rd_valid && tlast_f_q[rd_bank_q] && (row_cnt_q == CW'(LINES - 1));
  assign block_o.tuser  = rd_valid && tuser_f_q[rd_bank_q] && (row_cnt_q == '0);
  assign block_o.tstrb  = '1;
  assign block_o.tkeep  = '1;
  assign block_o.tid    = 1'b0;
  assign block_o.tdest  = 1'b0;

endmodule

// File: tb/tb_col_to_block_converter.sv
// Directed testbench for col_to_block_converter (8x8 blocks, 8-bit pixels).
module tb_col_to_block_converter;

  localparam int unsigned PXW = 8;
  localparam int unsigned LN  = 8;
  localparam int unsigned BW  = 64;
  localparam int unsigned FRX = 1280;

  typedef logic [7:0] blk_t [8][8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  int acc_cnt = 0;
  int last_acc_cyc = 0;

  logic [63:0] o_data [$];
  bit          o_last [$];
  bit          o_user [$];
  int          o_cyc  [$];

  axi4_stream_if #(.DATA_W(BW)) in_if ();
  axi4_stream_if #(.DATA_W(BW)) out_if ();

  col_to_block_converter #(
    .PX_WIDTH   (PXW),
    .LINES      (LN),
    .FRAME_RES_X(FRX)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .par_video_i(in_if),
    .block_o    (out_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] shf(input logic [7:0] p);
`ifdef LEVEL_SHIFT_EN
    return p - 8'h80;
`else
    return p;
`endif
  endfunction

  function automatic blk_t gen_blk(input int seed);
    blk_t b;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++)
        b[k][c] = 8'((seed + 8 * k + c) & 255);
    return b;
  endfunction

  function automatic logic [63:0] col_word(input blk_t b, input int c);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = b[k][c];
    return w;
  endfunction

  function automatic logic [63:0] row_word(input blk_t b, input int r, input int lc);
    logic [63:0] w;
    for (int c = 0; c < 8; c++) w[8*c +: 8] = shf(b[r][(c > lc) ? lc : c]);
    return w;
  endfunction

  task automatic drive_beat(input logic [63:0] d, input bit last, input bit user);
    int n;
    int sc;
    bit got;
    in_if.tdata  = d;
    in_if.tlast  = last;
    in_if.tuser  = user;
    in_if.tvalid = 1'b1;
    got = 1'b0;
    n   = 0;
    sc  = 0;
    while (!got && n < 500) begin
      @(negedge clk);
      got = in_if.tready;
      sc  = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    if (got) begin
      acc_cnt++;
      last_acc_cyc = sc;
    end else begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: tready=0 for %0d cycles, required 1", n);
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
  endtask

  task automatic send_block(input blk_t b, input int ncols, input bit last, input bit user);
    for (int c = 0; c < ncols; c++)
      drive_beat(col_word(b, c), last && (c == ncols - 1), user && (c == 0));
  endtask

  task automatic collect(input int n, input int budget);
    int t;
    t = 0;
    while (o_data.size() < n && t < budget) begin
      @(negedge clk);
      if (out_if.tvalid && out_if.tready) begin
        o_data.push_back(out_if.tdata);
        o_last.push_back(out_if.tlast);
        o_user.push_back(out_if.tuser);
        o_cyc.push_back(cyc);
      end
      t++;
      @(posedge clk);
      #1;
    end
    if (o_data.size() < n) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: got %0d beats, required %0d", o_data.size(), n);
    end
  endtask

  task automatic clear_out();
    o_data.delete();
    o_last.delete();
    o_user.delete();
    o_cyc.delete();
  endtask

  task automatic test_reset();
    in_if.tvalid = 1'b1;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
    in_if.tstrb  = '1;
    in_if.tkeep  = '1;
    in_if.tid    = 1'b0;
    in_if.tdest  = 1'b0;
    out_if.tready = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", out_if.tvalid); end
    checks++; if (out_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b, required 0", out_if.tlast); end
    checks++; if (out_if.tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b, required 0", out_if.tuser); end
    checks++; if (out_if.tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata: got %h, required 0", out_if.tdata); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready: got %b, required 0", in_if.tready); end
    in_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_if.tready !== 1'b1) begin errors++; $display("FAIL post_reset_in_tready: got %b, required 1", in_if.tready); end
    checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid: got %b, required 0", out_if.tvalid); end
  endtask

  task automatic test_basic();
    blk_t b0, b1;
    int lat_ref;
    b0 = gen_blk(0);
    b1 = gen_blk(64);
    lat_ref = 0;
    clear_out();
    out_if.tready = 1'b1;
    fork
      begin
        send_block(b0, 8, 1'b0, 1'b0);
        lat_ref = last_acc_cyc;
        send_block(b1, 8, 1'b1, 1'b0);
      end
      collect(16, 200);
    join
    if (o_data.size() == 16) begin
      checks++; if (o_cyc[0] !== lat_ref + 1) begin errors++; $display("FAIL basic_latency: first row cycle %0d, required %0d", o_cyc[0], lat_ref + 1); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (o_data[i] !== row_word((i < 8) ? b0 : b1, i % 8, 7)) begin
          errors++;
          $display("FAIL basic_row%0d: got %h, required %h", i, o_data[i], row_word((i < 8) ? b0 : b1, i % 8, 7));
        end
        checks++;
        if (o_last[i] !== (i == 15)) begin errors++; $display("FAIL basic_tlast%0d: got %b, required %b", i, o_last[i], (i == 15)); end
        checks++;
        if (o_user[i] !== 1'b0) begin errors++; $display("FAIL basic_tuser%0d: got %b, required 0", i, o_user[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    int nlast;
    clear_out();
    out_if.tready = 1'b1;
    fork
      begin
        for (int n = 0; n < 160; n++) send_block(gen_blk(n * 7), 8, n == 159, 1'b0);
      end
      collect(1280, 2000);
    join
    checks++;
    if (o_data.size() !== 1280) begin errors++; $display("FAIL b2b_count: got %0d, required 1280", o_data.size()); end
    if (o_data.size() == 1280) begin
      gaps  = 0;
      nlast = 0;
      for (int i = 0; i < 1280; i++) begin
        checks++;
        if (o_data[i] !== row_word(gen_blk((i / 8) * 7), i % 8, 7)) begin
          errors++;
          $display("FAIL b2b_row%0d: got %h, required %h", i, o_data[i], row_word(gen_blk((i / 8) * 7), i % 8, 7));
        end
        if (i > 0 && o_cyc[i] != o_cyc[i-1] + 1) gaps++;
        if (o_last[i]) nlast++;
      end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps: got %0d, required 0", gaps); end
      checks++; if (nlast !== 1 || o_last[1279] !== 1'b1) begin errors++; $display("FAIL b2b_tlast: count %0d last %b, required 1 and 1", nlast, o_last[1279]); end
    end
  endtask

  task automatic test_tuser();
    blk_t b;
    clear_out();
    out_if.tready = 1'b1;
    fork
      begin
        for (int n = 0; n < 3; n++) begin
          b = gen_blk(n * 16);
          for (int c = 0; c < 8; c++)
            drive_beat(col_word(b, c), 1'b0, (n == 0 && c == 0) || (n == 1 && c == 3));
        end
      end
      collect(24, 200);
    join
    if (o_data.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (o_user[i] !== (i == 0)) begin errors++; $display("FAIL tuser_row%0d: got %b, required %b", i, o_user[i], (i == 0)); end
      end
    end
  endtask

  task automatic test_short();
    blk_t bs, bf;
    bs = gen_blk(48);
    bf = gen_blk(100);
    clear_out();
    out_if.tready = 1'b1;
    fork
      begin
        send_block(bs, 5, 1'b1, 1'b0);
        send_block(bf, 8, 1'b0, 1'b0);
      end
      collect(16, 200);
    join
    if (o_data.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (o_data[i] !== row_word((i < 8) ? bs : bf, i % 8, (i < 8) ? 4 : 7)) begin
          errors++;
          $display("FAIL short_row%0d: got %h, required %h", i, o_data[i], row_word((i < 8) ? bs : bf, i % 8, (i < 8) ? 4 : 7));
        end
        checks++;
        if (o_last[i] !== (i == 7)) begin errors++; $display("FAIL short_tlast%0d: got %b, required %b", i, o_last[i], (i == 7)); end
      end
    end
  endtask

  task automatic test_stall();
    clear_out();
    acc_cnt = 0;
    out_if.tready = 1'b0;
    fork
      begin
        for (int n = 0; n < 3; n++) send_block(gen_blk(n * 64 + 5), 8, 1'b0, 1'b0);
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        checks++; if (acc_cnt !== 16) begin errors++; $display("FAIL stall_accepted: got %0d, required 16", acc_cnt); end
        checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL stall_in_tready: got %b, required 0", in_if.tready); end
        checks++; if (out_if.tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid: got %b, required 1", out_if.tvalid); end
        out_if.tready = 1'b1;
      end
      collect(24, 300);
    join
    if (o_data.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (o_data[i] !== row_word(gen_blk((i / 8) * 64 + 5), i % 8, 7)) begin
          errors++;
          $display("FAIL stall_row%0d: got %h, required %h", i, o_data[i], row_word(gen_blk((i / 8) * 64 + 5), i % 8, 7));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    blk_t ba, bc;
    int extra;
    ba = gen_blk(200);
    bc = gen_blk(17);
    clear_out();
    out_if.tready = 1'b0;
    send_block(ba, 8, 1'b1, 1'b1);
    send_block(gen_blk(90), 3, 1'b0, 1'b0);
    checks++; if (out_if.tvalid !== 1'b1 || out_if.tuser !== 1'b1) begin errors++; $display("FAIL midrst_pre: tvalid %b tuser %b, required 1 1", out_if.tvalid, out_if.tuser); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, required 0", out_if.tvalid); end
    checks++; if (out_if.tdata !== 64'h0) begin errors++; $display("FAIL midrst_tdata: got %h, required 0", out_if.tdata); end
    checks++; if (out_if.tuser !== 1'b0) begin errors++; $display("FAIL midrst_tuser: got %b, required 0", out_if.tuser); end
    checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_in_tready: got %b, required 0", in_if.tready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_if.tready = 1'b1;
    fork
      send_block(bc, 8, 1'b0, 1'b0);
      collect(8, 100);
    join
    if (o_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (o_data[i] !== row_word(bc, i, 7)) begin errors++; $display("FAIL midrst_row%0d: got %h, required %h", i, o_data[i], row_word(bc, i, 7)); end
      end
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_if.tvalid) extra++;
      @(posedge clk);
      #1;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_extra_rows: got %0d, required 0", extra); end
  endtask

  task automatic test_level_shift();
    blk_t bz, bff;
    logic [63:0] exp_z, exp_f;
`ifdef LEVEL_SHIFT_EN
    exp_z = 64'h8080808080808080;
    exp_f = 64'h7F7F7F7F7F7F7F7F;
`else
    exp_z = 64'h0000000000000000;
    exp_f = 64'hFFFFFFFFFFFFFFFF;
`endif
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        bz[k][c]  = 8'h00;
        bff[k][c] = 8'hFF;
      end
    clear_out();
    out_if.tready = 1'b1;
    fork
      begin
        send_block(bz, 8, 1'b0, 1'b0);
        send_block(bff, 8, 1'b0, 1'b0);
      end
      collect(16, 200);
    join
    if (o_data.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (o_data[i] !== ((i < 8) ? exp_z : exp_f)) begin
          errors++;
          $display("FAIL lvl_row%0d: got %h, required %h", i, o_data[i], (i < 8) ? exp_z : exp_f);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_tuser();
    test_short();
    test_stall();
    test_reset_mid();
    test_level_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
